// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the two-port arbiter that fronts one
// 4x4 multiplier.
package mult_arb_pkg;

  localparam int OPER_W          = 4;
  localparam int PROD_W          = 8;
  localparam int TIMEOUT_DEFAULT = 31;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and multiplier signals of mult_arbiter, bundled for port
// connection. slave is the arbiter's view, master the environment's.
interface mult_arbiter_if;
  import mult_arb_pkg::*;

  // Handshakes: a requester raises req with stable operands and holds them
  // until ack pulses for one cycle; one done pulse (err alongside on a
  // timeout) follows each ack, and res holds until that port's next done.
  // mul_start pulses once per operation; mul_ready drops while the multiplier
  // is busy and rises with a valid mul_out.
  logic              req0;
  logic              req1;
  logic [OPER_W-1:0] a0;
  logic [OPER_W-1:0] b0;
  logic [OPER_W-1:0] a1;
  logic [OPER_W-1:0] b1;
  logic              ack0;
  logic              ack1;
  logic              done0;
  logic              done1;
  logic              err0;
  logic              err1;
  logic [PROD_W-1:0] res0;
  logic [PROD_W-1:0] res1;
  logic              mul_start;
  logic [OPER_W-1:0] mul_a;
  logic [OPER_W-1:0] mul_b;
  logic [PROD_W-1:0] mul_out;
  logic              mul_ready;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mul_out, mul_ready,
    output ack0, ack1, done0, done1, err0, err1, res0, res1,
           mul_start, mul_a, mul_b
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, mul_out, mul_ready,
    input  ack0, ack1, done0, done1, err0, err1, res0, res1,
           mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the port not granted last wins,
// otherwise the single requester wins. grant is only meaningful if a req is high.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates two requesters onto one shared multiplier, with a timeout that
// reports err and a zero product if the multiplier never answers.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  mult_arbiter_if.slave  bus,
  output arb_state_t     fsm_state
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state;
  arb_state_t        state_next;
  logic              ptr_last;
  logic              winner;
  logic              grant;
  logic              any_req;
  logic              take;
  logic              complete;
  logic              timed_out;
  logic [CNT_W-1:0]  cnt;
  logic [OPER_W-1:0] op_a;
  logic [OPER_W-1:0] op_b;
  logic [1:0]        ack_q;
  logic [1:0]        done_q;
  logic [1:0]        err_q;
  logic [PROD_W-1:0] res0_q;
  logic [PROD_W-1:0] res1_q;

  assign any_req = bus.req0 | bus.req1;

  rr_pick2 u_pick (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .last  (ptr_last),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A late product in WAIT_DONE beats the timeout; in WAIT_BUSY the timeout wins.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    complete   = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          take       = 1'b1;
          state_next = START;
        end
      end
      START: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (cnt == CNT_LAST) begin
          timed_out  = 1'b1;
          state_next = RESP;
        end else if (!bus.mul_ready) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.mul_ready) begin
          complete   = 1'b1;
          state_next = RESP;
        end else if (cnt == CNT_LAST) begin
          timed_out  = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_last <= 1'b1;
      winner   <= 1'b0;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      ack_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      res0_q   <= '0;
      res1_q   <= '0;
    end else begin
      ack_q  <= 2'b00;
      done_q <= 2'b00;
      err_q  <= 2'b00;
      if (take) begin
        winner   <= grant;
        ptr_last <= grant;
        op_a     <= grant ? bus.a1 : bus.a0;
        op_b     <= grant ? bus.b1 : bus.b0;
        ack_q    <= grant ? 2'b10 : 2'b01;
        cnt      <= '0;
      end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (complete || timed_out) begin
        done_q <= winner ? 2'b10 : 2'b01;
        if (timed_out) begin
          err_q <= winner ? 2'b10 : 2'b01;
        end
        if (winner) begin
          res1_q <= complete ? bus.mul_out : '0;
        end else begin
          res0_q <= complete ? bus.mul_out : '0;
        end
      end
    end
  end

  assign bus.ack0      = ack_q[0];
  assign bus.ack1      = ack_q[1];
  assign bus.done0     = done_q[0];
  assign bus.done1     = done_q[1];
  assign bus.err0      = err_q[0];
  assign bus.err1      = err_q[1];
  assign bus.res0      = res0_q;
  assign bus.res1      = res1_q;
  assign bus.mul_start = (state == START);
  assign bus.mul_a     = op_a;
  assign bus.mul_b     = op_b;
  assign fsm_state     = state;

endmodule
